// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - 2:1 datapath mux with registered output and saturating select-toggle counter taps
// Define MUX2_PARITY_EN to add the registered even-parity output dataParity.
module mux_2x1 #(
   parameter int BIT_SIZE  = 32,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BIT_SIZE-1:0]  dataA,
   input  logic [BIT_SIZE-1:0]  dataB,
   input  logic                 dataSel,
   output logic [BIT_SIZE-1:0]  dataOut,
   output logic [BIT_SIZE-1:0]  dataOutQ,
`ifdef MUX2_PARITY_EN
   output logic [CNT_WIDTH-1:0] selToggleCnt,
   output logic                 dataParity
`else
   output logic [CNT_WIDTH-1:0] selToggleCnt
`endif
);

   logic selPrev;
   logic selToggled;
   logic cntSaturated;

   // Unknown select falls to the default arm so dataA passes without X-propagation.
   always_comb begin
      dataOut = dataA;
      case (dataSel)
         1'b1:    dataOut = dataB;
         default: dataOut = dataA;
      endcase
   end

   assign selToggled   = (dataSel != selPrev);
   assign cntSaturated = &selToggleCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dataOutQ     <= '0;
         selPrev      <= 1'b0;
         selToggleCnt <= '0;
      end else begin
         dataOutQ <= dataOut;
         selPrev  <= dataSel;
         if (selToggled && !cntSaturated) begin
            selToggleCnt <= selToggleCnt + CNT_WIDTH'(1);
         end
      end
   end

`ifdef MUX2_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dataParity <= 1'b0;
      end else begin
         dataParity <= ^dataOut;
      end
   end
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// tb/tb_mux_2x1.sv - scoreboard testbench for mux_2x1 with randomized stimulus
// Parity checks are active when MUX2_PARITY_EN is defined.
module tb_mux_2x1;

   typedef struct packed {
      logic [31:0] q;
      logic [7:0]  cnt;
      logic        par;
   } exp_t;

   logic        clk;
   logic        clkEn;
   logic        rst_n;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic        dataSel;
   logic [31:0] dataOut;
   logic [31:0] dataOutQ;
   logic [7:0]  selToggleCnt;
`ifdef MUX2_PARITY_EN
   logic        dataParity;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t expQ[$];
   exp_t monE;
   int   toggles;
   logic mPrev;

   mux_2x1 #(.BIT_SIZE(32), .CNT_WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dataA        (dataA),
      .dataB        (dataB),
      .dataSel      (dataSel),
      .dataOut      (dataOut),
      .dataOutQ     (dataOutQ),
`ifdef MUX2_PARITY_EN
      .selToggleCnt (selToggleCnt),
      .dataParity   (dataParity)
`else
      .selToggleCnt (selToggleCnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clkEn) clk = ~clk;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic modelReset();
      toggles = 0;
      mPrev   = 1'b0;
   endtask

   // Drive one cycle of stimulus and queue what the registered taps must show after the next edge.
   task automatic step(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      @(negedge clk);
      dataA   = a;
      dataB   = b;
      dataSel = s;
      if (s != mPrev) toggles++;
      mPrev  = s;
      e.q    = s ? b : a;
      e.cnt  = (toggles > 255) ? 8'hFF : 8'(toggles);
      e.par  = ($countones(e.q) % 2) == 1;
      expQ.push_back(e);
      #1;
      check("dataOut comb", {32'h0, dataOut}, {32'h0, e.q});
   endtask

   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         check("dataOutQ", {32'h0, dataOutQ}, {32'h0, monE.q});
         check("selToggleCnt", {56'h0, selToggleCnt}, {56'h0, monE.cnt});
`ifdef MUX2_PARITY_EN
         check("dataParity", {63'h0, dataParity}, {63'h0, monE.par});
`endif
      end
   end

   initial begin
      clkEn   = 1'b0;
      rst_n   = 1'b0;
      dataA   = 32'hFFFFFFFF;
      dataB   = 32'h11111111;
      dataSel = 1'b0;
      modelReset();

      // Clockless, in reset: combinational path only.
      #500;
      check("noclk sel0", {32'h0, dataOut}, {32'h0, 32'hFFFFFFFF});
      check("reset dataOutQ", {32'h0, dataOutQ}, 64'h0);
      check("reset selToggleCnt", {56'h0, selToggleCnt}, 64'h0);
`ifdef MUX2_PARITY_EN
      check("reset dataParity", {63'h0, dataParity}, 64'h0);
`endif
      dataSel = 1'b1;
      #500;
      check("noclk sel1", {32'h0, dataOut}, {32'h0, 32'h11111111});
      dataSel = 1'bx;
      #10;
      check("selX defaults to dataA", {32'h0, dataOut}, {32'h0, 32'hFFFFFFFF});
      dataSel = 1'b0;

      clkEn = 1'b1;
      repeat (2) @(negedge clk);
      check("held in reset with clk", {24'h0, dataOutQ, selToggleCnt}, 64'h0);
      rst_n = 1'b1;

      step(32'hFFFFFFFF, 32'h11111111, 1'b0);
      step(32'hFFFFFFFF, 32'h11111111, 1'b1);

      step(32'hFFFFFFFF, 32'h11111111, 1'b1);
      step(32'h12345678, 32'h00000001, 1'b1);

      // Static select with moving data must not count as toggles.
      for (int i = 0; i < 20; i++) step($urandom, $urandom, 1'b1);

      for (int i = 0; i < 300; i++) step($urandom, $urandom, (i % 2) == 0);
      @(negedge clk);
      check("saturated count", {56'h0, selToggleCnt}, {56'h0, 8'hFF});

      step($urandom, $urandom, 1'b1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async reset dataOutQ", {32'h0, dataOutQ}, 64'h0);
      check("async reset selToggleCnt", {56'h0, selToggleCnt}, 64'h0);
`ifdef MUX2_PARITY_EN
      check("async reset dataParity", {63'h0, dataParity}, 64'h0);
`endif
      dataA   = 32'hA5A5A5A5;
      dataB   = 32'h5A5A5A5A;
      dataSel = 1'b0;
      #1;
      check("reset dataOut sel0", {32'h0, dataOut}, {32'h0, 32'hA5A5A5A5});
      dataSel = 1'b1;
      #1;
      check("reset dataOut sel1", {32'h0, dataOut}, {32'h0, 32'h5A5A5A5A});
      rst_n = 1'b1;
      modelReset();

      step(32'hCAFEF00D, 32'h0BADBEEF, 1'b1);
      for (int i = 0; i < 200; i++) step($urandom, $urandom, 1'($urandom));

      @(posedge clk);
      #3;
      check("scoreboard drained", 64'(expQ.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
